instruction_decode_controller: RTL and testbench
================================================

// Module: instruction_decode_controller
// PURPOSE
//  Initiator side of the add_controller start/busy/done interface. Fetches 32-bit words from a
//  synchronous instruction ROM at pc, decodes ADD/ADDI/NOP/HALT, drives operands to the add
//  controller with a 1-cycle start pulse, waits for completion and adopts its next_pc.
//  Sits between instruction memory and the execute controllers in the processor top.
// PARAMETERS
//  RESET_PC        5'd0   pc value loaded on reset
//  RET_W           16     width of retired-instruction counter
//  TIMEOUT_CYCLES  64     watchdog limit in cycles (used only with DECODE_TIMEOUT_EN)
// PORTS
//  clk                     in   1   clock, all logic on posedge
//  rst                     in   1   synchronous, active-high reset
//  run                     in   1   fetch enable, sampled in FETCH only
//  imem_addr               out  5   ROM address, always equal to pc
//  imem_rdata              in   32  ROM data, valid 1 cycle after imem_addr
//  start                   out  1   1-cycle start pulse to add controller
//  operation_type          out  2   0=R (ADD), 1=I (ADDI)
//  source_1_address        out  5   rs1
//  source_2_address        out  5   rs2 (0 for I-type)
//  destination_address     out  5   rd
//  source_immediate_value  out  32  {imm16,16'h0000} for I-type, 0 for R-type
//  pc                      out  5   current program counter
//  next_pc                 in   5   pc returned by add controller, valid with done
//  busy                    in   1   add controller busy
//  done                    in   1   add controller done (sticky until next start)
//  halted                  out  1   HALT executed or watchdog fired
//  illegal_op              out  1   sticky: undefined opcode decoded
//  retired_count           out  RET_W  instructions completed (ADD/ADDI/NOP), saturating
//  timeout_err             out  1   sticky watchdog flag (0 when macro absent)
// BEHAVIOUR
//  Encoding: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16.
//   Opcodes: 6'h00 NOP, 6'h01 ADD, 6'h02 ADDI, 6'h3F HALT, others illegal.
//  Reset: state=FETCH, pc=RESET_PC; every other output 0.
//  FETCH: run=1 -> DECODE (ROM data valid next cycle); run=0 -> stay.
//  DECODE: latch imem_rdata fields into operand outputs.
//   ADD/ADDI -> ISSUE. NOP -> pc<=pc+1, retired++, -> FETCH.
//   HALT -> HALTED. Illegal -> illegal_op<=1, pc<=pc+1, no retire, -> FETCH.
//  ISSUE: start=1 for exactly this cycle -> WAIT_ACK.
//  WAIT_ACK: busy=1 -> WAIT_DONE. The stale done level from the previous op is ignored here.
//  WAIT_DONE: done=1 -> pc<=next_pc, retired++ -> FETCH.
//  HALTED: halted=1. Stays until rst. start is never asserted.
//  Operand outputs are held stable from DECODE until the next DECODE.
//  pc is 5-bit and wraps: 31+1 -> 0. retired_count saturates at all-ones.
//  Latency: FETCH entry to start high = 2 cycles. Minimum 4 cycles per NOP-free op plus controller time.
//  rst in any state, including WAIT_DONE, forces the reset values the next cycle.
//   The add controller shares rst, so no transaction survives reset.
// CONFIGURATION
//  DECODE_TIMEOUT_EN defined:
//   - A counter clears on ISSUE and increments each cycle in WAIT_ACK/WAIT_DONE.
//   - At TIMEOUT_CYCLES: timeout_err<=1, halted<=1, -> HALTED.
//  Undefined: no counter. Waits indefinitely. timeout_err tied 0.
// TESTING
//  1 rst, imem[0]=ADD rd3 rs1=1 rs2=2, model ack+done(next_pc=1) -> start high 1 cycle,
//    op_type=0, addrs 1/2/3, pc=1, retired=1.
//  2 imem[0]=ADDI rd4 rs1=5 imm16=16'h3F80 -> op_type=1, src2_addr=0, imm=32'h3F800000.
//  3 imem[0]=opcode 6'h15 -> illegal_op=1, no start, pc=1, retired=0.
//  4 pc=31 NOP -> pc=0, retired+1. Then HALT at 0 -> halted=1, start stays 0 for 100 cycles.
//  5 rst pulse during WAIT_DONE -> pc=RESET_PC, start=0, flags cleared, refetch from RESET_PC.
//  6 DECODE_TIMEOUT_EN, TIMEOUT_CYCLES=8, busy tied 0 -> timeout_err=halted=1 8 cycles after ISSUE.
//    Without the macro -> stays in WAIT_ACK, timeout_err=0.

Source files
------------

// File: rtl/instruction_decode_controller.sv
// rtl/instruction_decode_controller.sv - fetch/decode/issue sequencer driving the add controller
// Optional watchdog on the add-controller handshake: define DECODE_TIMEOUT_EN.
module instruction_decode_controller #(
    parameter logic [4:0] RESET_PC       = 5'd0,
    parameter int         RET_W          = 16,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [4:0]        imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              start,
    output logic [1:0]        operation_type,
    output logic [4:0]        source_1_address,
    output logic [4:0]        source_2_address,
    output logic [4:0]        destination_address,
    output logic [31:0]       source_immediate_value,
    output logic [4:0]        pc,
    input  logic [4:0]        next_pc,
    input  logic              busy,
    input  logic              done,
    output logic              halted,
    output logic              illegal_op,
    output logic [RET_W-1:0]  retired_count,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_HALTED
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_ADDI = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] opcode;
    logic       retire;
    logic       pc_step;
    logic       pc_load;
    logic       set_illegal;
    logic       latch_ops;
    logic       wdog_fire;

    assign opcode    = imem_rdata[31:26];
    assign imem_addr = pc;

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;
        pc_step     = 1'b0;
        pc_load     = 1'b0;
        set_illegal = 1'b0;
        latch_ops   = 1'b0;
        case (state)
            S_FETCH: begin
                if (run) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                latch_ops = 1'b1;
                case (opcode)
                    OP_ADD, OP_ADDI: state_nxt = S_ISSUE;
                    OP_NOP: begin
                        pc_step   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_HALT: state_nxt = S_HALTED;
                    default: begin
                        set_illegal = 1'b1;
                        pc_step     = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                endcase
            end
            S_ISSUE: begin
                start     = 1'b1;
                state_nxt = S_WAIT_ACK;
            end
            // done may still be high from the previous op; only busy proves this op was taken
            S_WAIT_ACK: begin
                if (busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done) begin
                    pc_load   = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALTED: halted = 1'b1;
            default:  state_nxt = S_FETCH;
        endcase
        if (wdog_fire) state_nxt = S_HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= S_FETCH;
            pc                     <= RESET_PC;
            retired_count          <= '0;
            illegal_op             <= 1'b0;
            operation_type         <= '0;
            source_1_address       <= '0;
            source_2_address       <= '0;
            destination_address    <= '0;
            source_immediate_value <= '0;
        end else begin
            state <= state_nxt;
            if (pc_step)      pc <= pc + 5'd1;
            else if (pc_load) pc <= next_pc;
            if (retire && (retired_count != '1)) retired_count <= retired_count + RET_W'(1);
            if (set_illegal) illegal_op <= 1'b1;
            if (latch_ops) begin
                destination_address <= imem_rdata[25:21];
                source_1_address    <= imem_rdata[20:16];
                // rs2 and imm16 overlap in the encoding; I-type reports rs2 as 0
                if (opcode == OP_ADDI) begin
                    operation_type         <= 2'd1;
                    source_2_address       <= '0;
                    source_immediate_value <= {imem_rdata[15:0], 16'h0000};
                end else begin
                    operation_type         <= 2'd0;
                    source_2_address       <= imem_rdata[15:11];
                    source_immediate_value <= '0;
                end
            end
        end
    end

`ifdef DECODE_TIMEOUT_EN
    // Firing at count TIMEOUT_CYCLES-2 lands the flag exactly TIMEOUT_CYCLES cycles after start
    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    logic [WD_W-1:0] wdog_cnt;

    always_comb begin
        wdog_fire = ((state == S_WAIT_ACK) || ((state == S_WAIT_DONE) && !done))
                    && (wdog_cnt == WD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_ISSUE) wdog_cnt <= '0;
            else if ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) wdog_cnt <= wdog_cnt + WD_W'(1);
            if (wdog_fire) timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wdog_fire          = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_instruction_decode_controller.sv
// tb/tb_instruction_decode_controller.sv - self-checking bench for instruction_decode_controller
module tb_instruction_decode_controller;

    localparam int RET_W = 4;
    localparam logic [31:0] W_HALT = {6'h3F, 26'h0};
    localparam logic [31:0] W_NOP  = 32'h0;
    localparam logic [31:0] W_ILL  = {6'h15, 26'h0};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic [4:0]        imem_addr;
    logic [31:0]       imem_rdata;
    logic              start;
    logic [1:0]        operation_type;
    logic [4:0]        source_1_address;
    logic [4:0]        source_2_address;
    logic [4:0]        destination_address;
    logic [31:0]       source_immediate_value;
    logic [4:0]        pc;
    logic [4:0]        next_pc;
    logic              busy;
    logic              done;
    logic              halted;
    logic              illegal_op;
    logic [RET_W-1:0]  retired_count;
    logic              timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_decode_controller #(
        .RESET_PC(5'd0), .RET_W(RET_W), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .start(start), .operation_type(operation_type),
        .source_1_address(source_1_address), .source_2_address(source_2_address),
        .destination_address(destination_address),
        .source_immediate_value(source_immediate_value),
        .pc(pc), .next_pc(next_pc), .busy(busy), .done(done),
        .halted(halted), .illegal_op(illegal_op),
        .retired_count(retired_count), .timeout_err(timeout_err)
    );

    logic [31:0] rom [32];
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'h0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    // {op_type, rs1, rs2, rd, imm} the add controller must see for an instruction word
    function automatic logic [48:0] exp_ops(input logic [31:0] w);
        if (w[31:26] == 6'h02) return {2'd1, w[20:16], 5'd0, w[25:21], w[15:0], 16'h0};
        return {2'd0, w[20:16], w[15:11], w[25:21], 32'h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // add controller: busy for ctrl_work cycles after start, then sticky done with next_pc
    int         ctrl_work = 3;
    bit         ctrl_en = 1'b1;
    bit         jump_en = 1'b0;
    logic [4:0] jump_pc = 5'd0;
    logic [4:0] ctrl_target = 5'd0;
    int         cw = 0;

    initial begin
        busy = 1'b0;
        done = 1'b0;
        next_pc = 5'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                busy = 1'b0;
                done = 1'b0;
                cw = 0;
            end else if (cw > 0) begin
                cw--;
                if (cw == 0) begin
                    busy = 1'b0;
                    done = 1'b1;
                    next_pc = ctrl_target;
                end
            end else if (start && ctrl_en) begin
                done = 1'b0;
                busy = 1'b1;
                cw = ctrl_work;
                ctrl_target = jump_en ? jump_pc : pc + 5'd1;
            end
        end
    end

    // architectural model: one step per completed instruction
    logic [4:0] m_pc = 5'd0;
    logic [4:0] prev_pc = 5'd0;
    int         m_retired = 0;
    logic       m_ill = 1'b0;
    bit         m_issued = 1'b0;
    bit         prev_start = 1'b0;
    int         start_cnt = 0;

    function automatic logic [RET_W-1:0] sat_ret(input int n);
        int lim;
        lim = (1 << RET_W) - 1;
        return RET_W'((n > lim) ? lim : n);
    endfunction

    task automatic model_step();
        logic [31:0] w;
        w = rom[m_pc];
        case (w[31:26])
            6'h00: begin
                m_pc = m_pc + 5'd1;
                m_retired++;
            end
            6'h01, 6'h02: begin
                chk("retire_without_issue", m_issued, 1);
                m_pc = ctrl_target;
                m_retired++;
            end
            6'h3F: begin
                checks++;
                failures++;
                $display("FAIL halt_advanced actual_pc=%0d required_pc=%0d", pc, m_pc);
            end
            default: begin
                m_pc = m_pc + 5'd1;
                m_ill = 1'b1;
            end
        endcase
        m_issued = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_pc = 5'd0;
                prev_pc = 5'd0;
                m_retired = 0;
                m_ill = 1'b0;
                m_issued = 1'b0;
                prev_start = 1'b0;
                chk("rst_pc", pc, 0);
                chk("rst_start", start, 0);
                chk("rst_flags", {halted, illegal_op, timeout_err}, 0);
                chk("rst_retired", retired_count, 0);
                chk("rst_ops", {operation_type, source_1_address, source_2_address,
                                destination_address, source_immediate_value}, 0);
            end else begin
                if (pc !== prev_pc) model_step();
                chk("imem_addr", imem_addr, m_pc);
                chk("pc", pc, m_pc);
                chk("retired", retired_count, sat_ret(m_retired));
                chk("illegal", illegal_op, m_ill);
                if (start) begin
                    start_cnt++;
                    w = rom[m_pc];
                    chk("start_width", prev_start, 0);
                    chk("one_issue", m_issued, 0);
                    m_issued = 1'b1;
                    chk("issue_kind", (w[31:26] == 6'h01) || (w[31:26] == 6'h02), 1);
                    chk("issue_ops", {operation_type, source_1_address, source_2_address,
                                      destination_address, source_immediate_value}, exp_ops(w));
                end
                if (halted) begin
                    chk("halted_no_start", start, 0);
                    chk("halted_cause", (rom[m_pc][31:26] == 6'h3F) || timeout_err, 1);
                end
`ifdef DECODE_TIMEOUT_EN
                if (timeout_err) chk("timeout_halts", halted, 1);
`else
                chk("timeout_off", timeout_err, 0);
`endif
                prev_pc = pc;
                prev_start = start;
            end
        end
    end

    task automatic load_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        repeat (2) @(negedge clk);
        start_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 32; i++) rom[i] = w;
    endtask

    task automatic wait_start(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = start;
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_halted(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = halted;
        end
        chk(name, ok, 1);
    endtask

    initial begin
        int n_start;
        int n_unhalt;
        bit ok;
        fill(W_HALT);

        // 1: ADD with 2-cycle issue latency and single-cycle start
        fill(W_HALT);
        rom[0] = enc_r(6'h01, 5'd3, 5'd1, 5'd2);
        ctrl_work = 3;
        load_reset();
        @(posedge clk); #1;
        chk("t1_lat_decode", start, 0);
        @(posedge clk); #1;
        chk("t1_lat_issue", start, 1);
        chk("t1_ops", {operation_type, source_1_address, source_2_address, destination_address,
                       source_immediate_value}, {2'd0, 5'd1, 5'd2, 5'd3, 32'h0});
        @(posedge clk); #1;
        chk("t1_pulse", start, 0);
        wait_halted("t1_halt_wait", 50);
        chk("t1_pc", pc, 1);
        chk("t1_retired", retired_count, 1);
        chk("t1_starts", start_cnt, 1);

        // 2: ADDI then ADD issued while the previous done is still high
        fill(W_HALT);
        rom[0] = enc_i(6'h02, 5'd4, 5'd5, 16'h3F80);
        rom[1] = enc_r(6'h01, 5'd7, 5'd8, 5'd9);
        ctrl_work = 2;
        load_reset();
        wait_start("t2_start_addi", 20);
        chk("t2_addi_ops", {operation_type, source_1_address, source_2_address, destination_address,
                            source_immediate_value}, {2'd1, 5'd5, 5'd0, 5'd4, 32'h3F800000});
        wait_start("t2_start_add", 30);
        chk("t2_add_pc", pc, 1);
        chk("t2_add_ops", {operation_type, source_1_address, source_2_address, destination_address,
                           source_immediate_value}, {2'd0, 5'd8, 5'd9, 5'd7, 32'h0});
        wait_halted("t2_halt_wait", 50);
        chk("t2_pc", pc, 2);
        chk("t2_retired", retired_count, 2);

        // 3: undefined opcode
        fill(W_HALT);
        rom[0] = W_ILL;
        load_reset();
        wait_halted("t3_halt_wait", 50);
        chk("t3_illegal", illegal_op, 1);
        chk("t3_pc", pc, 1);
        chk("t3_retired", retired_count, 0);
        chk("t3_starts", start_cnt, 0);

        // 4: jump to 31, NOP wraps pc to 0, HALT there and stay quiet
        fill(W_HALT);
        rom[0] = enc_r(6'h01, 5'd1, 5'd1, 5'd1);
        rom[31] = W_NOP;
        jump_en = 1'b1;
        jump_pc = 5'd31;
        ctrl_work = 3;
        load_reset();
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            ok = (pc == 5'd31);
        end
        chk("t4_reach_31", ok, 1);
        @(negedge clk);
        rom[0] = W_HALT;
        jump_en = 1'b0;
        wait_halted("t4_halt_wait", 50);
        chk("t4_wrap_pc", pc, 0);
        chk("t4_retired", retired_count, 2);
        n_start = 0;
        n_unhalt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (start) n_start++;
            if (!halted) n_unhalt++;
        end
        chk("t4_no_start", n_start, 0);
        chk("t4_halt_hold", n_unhalt, 0);

        // 5: reset in WAIT_DONE, then clean refetch from pc 0
        fill(W_HALT);
        rom[0] = W_ILL;
        rom[1] = enc_r(6'h01, 5'd2, 5'd3, 5'd4);
        ctrl_work = 20;
        load_reset();
        wait_start("t5_start", 30);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pre_illegal", illegal_op, 1);
        chk("t5_pre_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_pc", pc, 0);
        chk("t5_rst_start", start, 0);
        chk("t5_rst_flags", {halted, illegal_op}, 0);
        @(negedge clk);
        rst = 1'b0;
        ctrl_work = 3;
        wait_start("t5_restart", 30);
        chk("t5_refetch_pc", pc, 1);
        wait_halted("t5_halt_wait", 50);
        chk("t5_pc", pc, 2);
        chk("t5_retired", retired_count, 1);

        // 6: controller never acknowledges
        fill(W_HALT);
        rom[0] = enc_r(6'h01, 5'd1, 5'd2, 5'd3);
        ctrl_en = 1'b0;
        load_reset();
        wait_start("t6_start", 20);
`ifdef DECODE_TIMEOUT_EN
        repeat (7) @(posedge clk);
        #1;
        chk("t6_before_timeout", {timeout_err, halted}, 0);
        @(posedge clk); #1;
        chk("t6_timeout", {timeout_err, halted}, 2'b11);
`else
        repeat (100) @(posedge clk);
        #1;
        chk("t6_no_timeout", {timeout_err, halted}, 0);
        chk("t6_pc_held", pc, 0);
        chk("t6_retired", retired_count, 0);
`endif
        ctrl_en = 1'b1;

        // 7: NOP stream saturates the counter; run=0 holds in FETCH
        fill(W_NOP);
        load_reset();
        repeat (40) @(posedge clk);
        #1;
        chk("t7_pc", pc, 20);
        chk("t7_saturated", retired_count, 15);
        @(negedge clk);
        run = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t7_run_hold", pc, 20);
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t7_resume", pc, 21);
        chk("t7_still_sat", retired_count, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
